// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported SRAM between fetch (read-only) and memory stage (read/write), MEM has priority.
// Latency: ready pulses WAIT_CYCLES+1 cycles after the request is sampled in IDLE; grants are spaced WAIT_CYCLES+2 apart.
// Backpressure: requesters hold their request until ready; freeze outputs stall their pipeline stages meanwhile.
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 5,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    output logic              if_freeze,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              mem_freeze,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t            state;
    logic              grant_mem;
    logic              we_q;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              mem_req;
    logic              unused_addr_bits;

    assign mem_req = mem_rd_en | mem_wr_en;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_mem <= 1'b0;
            we_q      <= 1'b0;
            cnt       <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            if_rdata  <= 32'd0;
            mem_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        // A simultaneous read+write is serviced as a write.
                        grant_mem <= 1'b1;
                        we_q      <= mem_wr_en;
                        addr_q    <= mem_addr[ADDR_W+1:2];
                        wdata_q   <= mem_wdata;
                        cnt       <= 4'd0;
                        state     <= ACCESS;
                    end else if (if_req) begin
                        grant_mem <= 1'b0;
                        we_q      <= 1'b0;
                        addr_q    <= if_addr[ADDR_W+1:2];
                        cnt       <= 4'd0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_CNT) begin
                        if (!we_q) begin
                            if (grant_mem) mem_rdata <= sram_rdata;
                            else           if_rdata  <= sram_rdata;
                        end
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign sram_en    = (state == ACCESS);
    assign sram_we    = (state == ACCESS) & we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

    assign if_ready   = (state == DONE) & ~grant_mem;
    assign mem_ready  = (state == DONE) &  grant_mem;
    assign if_freeze  = if_req  & ~if_ready;
    assign mem_freeze = mem_req & ~mem_ready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: a WAIT_CYCLES=5 instance for the directed cases
// and a WAIT_CYCLES=1 instance for back-to-back fetches; both share one SRAM model.
module tb_mem_port_arbiter;
    localparam int W = 5;

    typedef struct {
        int          cyc;
        bit          is_mem;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t exp1_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        if_req, if_ready, if_freeze, mem_rd_en, mem_wr_en, mem_ready, mem_freeze;
    logic        sram_en, sram_we;
    logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata, sram_wdata, sram_rdata;
    logic [15:0] sram_addr;

    logic        w1_if_req, w1_if_ready, w1_if_freeze, w1_mem_ready, w1_mem_freeze, w1_sram_en, w1_sram_we;
    logic [31:0] w1_if_addr, w1_if_rdata, w1_mem_rdata, w1_sram_wdata, w1_sram_rdata;
    logic [15:0] w1_sram_addr;

    logic [31:0] sram [0:65535];

    mem_port_arbiter #(.WAIT_CYCLES(W), .ADDR_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_freeze(if_freeze),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_freeze(mem_freeze),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    mem_port_arbiter #(.WAIT_CYCLES(1), .ADDR_W(16)) u_dut_w1 (
        .clk(clk), .rst(rst),
        .if_req(w1_if_req), .if_addr(w1_if_addr), .if_rdata(w1_if_rdata), .if_ready(w1_if_ready),
        .if_freeze(w1_if_freeze),
        .mem_rd_en(1'b0), .mem_wr_en(1'b0), .mem_addr(32'd0), .mem_wdata(32'd0),
        .mem_rdata(w1_mem_rdata), .mem_ready(w1_mem_ready), .mem_freeze(w1_mem_freeze),
        .sram_en(w1_sram_en), .sram_we(w1_sram_we), .sram_addr(w1_sram_addr), .sram_wdata(w1_sram_wdata),
        .sram_rdata(w1_sram_rdata)
    );

    always @(posedge clk) if (sram_en && sram_we) sram[sram_addr] <= sram_wdata;
    assign sram_rdata    = sram[sram_addr];
    assign w1_sram_rdata = sram[w1_sram_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor for the WAIT_CYCLES=5 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (if_ready || mem_ready)) begin
            n_chk++;
            if (exp_q.size() == 0 || (if_ready && mem_ready)) begin
                n_fail++;
                $display("FAIL unexpected_ready: if_ready=%b mem_ready=%b, expected none (cycle %0d)",
                         if_ready, mem_ready, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.is_mem !== mem_ready || e.cyc != cyc ||
                    (mem_ready ? mem_rdata : if_rdata) !== e.data) begin
                    n_fail++;
                    $display("FAIL ready_check: got port_mem=%b cycle %0d data %h, expected port_mem=%b cycle %0d data %h",
                             mem_ready, cyc, mem_ready ? mem_rdata : if_rdata, e.is_mem, e.cyc, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && w1_if_ready) begin
            n_chk++;
            if (exp1_q.size() == 0) begin
                n_fail++;
                $display("FAIL w1_unexpected_ready: got ready at cycle %0d, expected none", cyc);
            end else begin
                e = exp1_q.pop_front();
                if (e.cyc != cyc || w1_if_rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL w1_ready_check: got cycle %0d data %h, expected cycle %0d data %h",
                             cyc, w1_if_rdata, e.cyc, e.data);
                end
            end
        end
    end

    // One access on the W=5 instance: checks the SRAM side during ACCESS and freeze release in DONE.
    task automatic access(input bit is_mem, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp);
        int c;
        bit we;
        c  = cyc;
        we = is_mem && wr;
        if (is_mem) begin
            mem_rd_en = rd; mem_wr_en = wr; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        exp_q.push_back('{c + W + 1, is_mem, exp});
        @(posedge clk);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("access_sram", {sram_en, sram_we, sram_addr}, {1'b1, we, addr[17:2]});
            if (we) chk("access_wdata", sram_wdata, wdata);
            chk("access_freeze", is_mem ? mem_freeze : if_freeze, 1'b1);
            if (i == 1) begin
                mem_addr = 32'hFFFF_FFFC; if_addr = 32'hFFFF_FFFC; mem_wdata = 32'h0;
            end
        end
        @(negedge clk);
        chk("done_state", {sram_en, sram_we, is_mem ? mem_freeze : if_freeze}, 3'b000);
        @(posedge clk); #1;
        if_req = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
    endtask

    initial begin
        int c;
        int t;
        int k;
        logic [31:0] w1_addr [0:4];
        for (int i = 0; i < 65536; i++) sram[i] = 32'd0;
        sram[4]          = 32'hE3A0_1005;
        sram[2]          = 32'hA5A5_0002;
        sram[16'hFFFF]   = 32'h1234_5678;
        rst = 1'b1;
        if_req = 0; if_addr = 0; mem_rd_en = 0; mem_wr_en = 0; mem_addr = 0; mem_wdata = 0;
        w1_if_req = 0; w1_if_addr = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_idle", {sram_en, sram_we, sram_addr, sram_wdata, if_rdata, mem_rdata,
                               if_ready, mem_ready, if_freeze, mem_freeze}, 64'd0);
        end
        @(posedge clk); #1;

        access(0, 0, 0, 32'h0000_0010, 32'h0,         32'hE3A0_1005);
        access(1, 0, 1, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0000_0000);
        access(1, 1, 0, 32'h0000_0400, 32'h0,         32'hDEAD_BEEF);
        access(1, 1, 0, 32'h0003_FFFC, 32'h0,         32'h1234_5678);
        access(0, 0, 0, 32'hF004_0008, 32'h0,         32'hA5A5_0002);
        access(1, 1, 1, 32'h0000_0008, 32'h0BAD_F00D, 32'h1234_5678);
        access(0, 0, 0, 32'h0000_0008, 32'h0,         32'h0BAD_F00D);

        // Simultaneous requests: MEM first, IF granted from the following IDLE.
        c = cyc;
        if_req = 1; if_addr = 32'h10; mem_rd_en = 1; mem_addr = 32'h400;
        exp_q.push_back('{c + 6,  1'b1, 32'hDEAD_BEEF});
        exp_q.push_back('{c + 13, 1'b0, 32'hE3A0_1005});
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (cyc < c + 13) chk("sim_if_freeze", if_freeze, 1'b1);
            if (cyc == c + 3) chk("sim_mem_addr", sram_addr, 16'h0100);
            if (cyc == c + 10) chk("sim_if_addr", {sram_en, sram_addr}, {1'b1, 16'h0004});
            if (cyc == c + 7) mem_rd_en = 0;
        end
        @(posedge clk); #1 if_req = 0;

        // Reset in the third ACCESS cycle aborts without a ready pulse.
        c = cyc;
        mem_rd_en = 1; mem_addr = 32'h400;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("rst_mid_sram_en", sram_en, 1'b1);
        @(negedge clk);
        chk("rst_abort", {sram_en, mem_ready, if_ready, mem_rdata}, 35'd0);
        @(posedge clk); #1 rst = 0; mem_rd_en = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_ready", {sram_en, mem_ready, if_ready}, 3'b000);
        end
        @(posedge clk); #1;
        access(1, 1, 0, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF);

        // WAIT_CYCLES=1 instance: fetch held continuously, address advanced on each ready.
        w1_addr[0] = 32'h10; w1_addr[1] = 32'h400; w1_addr[2] = 32'h8; w1_addr[3] = 32'h3FFFC; w1_addr[4] = 32'h0;
        c = cyc;
        exp1_q.push_back('{c + 2,  1'b0, 32'hE3A0_1005});
        exp1_q.push_back('{c + 5,  1'b0, 32'hDEAD_BEEF});
        exp1_q.push_back('{c + 8,  1'b0, 32'h0BAD_F00D});
        exp1_q.push_back('{c + 11, 1'b0, 32'h1234_5678});
        w1_if_req = 1; w1_if_addr = w1_addr[0];
        k = 0; t = 0;
        while (k < 4 && t < 30) begin
            @(negedge clk);
            t++;
            if (w1_if_ready) begin
                k++;
                w1_if_addr = w1_addr[k];
            end
        end
        chk("w1_completed", k, 4);
        @(posedge clk); #1 w1_if_req = 0;

        repeat (10) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("w1_queue_drained", exp1_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end
endmodule
